ssd_scan_mux: RTL and testbench
===============================

Name: ssd_scan_mux

Overview:
- Time-multiplexed digit scanner that sits directly upstream of the seven-segment encoder.
- Takes NUM_DIGITS packed 4-bit digit values (e.g. tens/units of the 0-99 counter) and presents one digit at a time on a 4-bit bus to the encoder.
- Drives the matching active-low anode line for each digit in turn.
- Adds frame-coherent digit buffering and inter-digit dead time to suppress ghosting.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot at 100 MHz); must be >= 4.
- DEAD_CYCLES, 16, cycles at slot start with all anodes off; must be < REFRESH_DIV.

Ports:
- ssd_scan_mux_port_clk  input  1  system clock, rising edge.
- ssd_scan_mux_port_rst  input  1  asynchronous, active-high reset.
- ssd_scan_mux_port_en  input  1  scan enable; low = display dark, scan frozen.
- ssd_scan_mux_port_digits  input  4*NUM_DIGITS  packed digits; [3:0] = digit 0 (rightmost).
- ssd_scan_mux_port_digit  output  4  current digit value, to encoder input.
- ssd_scan_mux_port_an  output  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones.
- ssd_scan_mux_port_blank  output  1  high when no anode is asserted.
- ssd_scan_mux_port_frame  output  1  one-cycle pulse at the start of each digit-0 slot.

Behaviour:
- Interface: one clock (ssd_scan_mux_port_clk); reset ssd_scan_mux_port_rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - prescaler 0; index NUM_DIGITS-1.
  - shadow digit buffer all 0.
  - digit 4'h0; an all ones; blank 1; frame 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while en=1, then wraps to 0; width $clog2(REFRESH_DIV).
  - tick = (prescaler == REFRESH_DIV-1) && en.
- Index on tick:
  - index <= (index == NUM_DIGITS-1) ? 0 : index+1.
  - When index wraps to 0, the shadow buffer captures ssd_scan_mux_port_digits in the same edge. This gives frame-coherent display with no tearing between digits.
- Slot timing:
  - A slot begins the cycle after tick; slot cycle k = prescaler value k.
  - digit = shadow[index] from slot cycle 0.
  - an = all ones for slot cycles 0..DEAD_CYCLES-1.
  - an[index] = 0 (others 1) for cycles DEAD_CYCLES..REFRESH_DIV-1.
- frame = 1 for slot cycle 0 of digit 0 only.
- blank = 1 exactly when an is all ones.
- First frame after reset: the first tick occurs REFRESH_DIV cycles after reset deassertion with en=1. It wraps index to 0, loads the shadow buffer and pulses frame.
- en deasserted:
  - prescaler and index hold; an all ones, blank 1 on the next edge; digit holds; no shadow load.
  - On re-enable, counting resumes from the held prescaler value. Dead time is not re-applied for the resumed slot unless the prescaler is < DEAD_CYCLES.
- Digits input changing mid-frame has no effect until the next digit-0 slot.
- Values 4'hA..4'hF are passed through unchanged; decoding is the encoder's job.
- Reset mid-slot forces all reset values immediately, independent of the clock.

Optional Feature:
- Macro: SSD_SCAN_MUX_LZB_EN (leading-zero blanking).
- Defined:
  - For index i >= 1, if shadow digits i..NUM_DIGITS-1 are all 4'h0, an stays all ones and blank = 1 for that whole slot.
  - digit still shows 4'h0. Digit 0 is never blanked.
  - Slot timing and frame are unchanged.
- Not defined: every digit is displayed, including leading zeros; no extra logic is synthesised.

Test Plan (NUM_DIGITS=2, REFRESH_DIV=8, DEAD_CYCLES=2):
- Reset: assert rst mid-slot with an=2'b10 -> an=2'b11, digit=0, blank=1, frame=0 with no clock edge. After release with en=1, the first frame pulse comes 8 cycles later.
- Digits=8'h47, en=1:
  - Slot 0: digit=7, an=11 for 2 cycles then 10 for 6 cycles.
  - Slot 1: digit=4, an=11 for 2 cycles then 01 for 6 cycles.
  - Pattern repeats every 16 cycles with frame on each slot-0 start.
- Coherence: change digits 8'h47 -> 8'h93 during slot 0 -> slot 1 still shows 4. Next slot 0 shows 3, then 9.
- Enable: drop en for 5 cycles mid-slot 1 -> an=11, blank=1, prescaler frozen. On re-enable the slot completes its remaining cycles, then slot 0 starts.
- Hex pass-through: digits=8'hFA -> digit sequence A, F.
- LZB (macro defined): digits=8'h05 -> slot 1 an=11 throughout, blank=1; slot 0 shows 5. digits=8'h00 -> digit 0 is still displayed with an=10. Without the macro, 8'h05 lights both digits.

Source files
------------

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed seven-segment digit scanner with frame-coherent shadow buffer and dead time.
// Optional leading-zero blanking is enabled by defining SSD_SCAN_MUX_LZB_EN.
module ssd_scan_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    ssd_scan_mux_port_clk,
  input  logic                    ssd_scan_mux_port_rst,
  input  logic                    ssd_scan_mux_port_en,
  input  logic [4*NUM_DIGITS-1:0] ssd_scan_mux_port_digits,
  output logic [3:0]              ssd_scan_mux_port_digit,
  output logic [NUM_DIGITS-1:0]   ssd_scan_mux_port_an,
  output logic                    ssd_scan_mux_port_blank,
  output logic                    ssd_scan_mux_port_frame
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_VAL = PW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler_reg, prescaler_next;
  logic [IW-1:0]         index_reg, index_next;
  logic [3:0]            shadow_reg  [NUM_DIGITS];
  logic [3:0]            shadow_next [NUM_DIGITS];
  logic [3:0]            digit_reg, digit_next;
  logic [NUM_DIGITS-1:0] an_reg, an_next;
  logic                  blank_reg, blank_next;
  logic                  frame_reg, frame_next;
  logic                  tick;
  logic                  wrap;
  logic                  lit;
  logic                  lzb_blank;

  always_comb begin
    tick           = ssd_scan_mux_port_en && (prescaler_reg == PRE_MAX);
    wrap           = tick && (index_reg == IDX_MAX);
    prescaler_next = prescaler_reg;
    index_next     = index_reg;
    if (ssd_scan_mux_port_en) begin
      prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
    end
    if (tick) begin
      index_next = (index_reg == IDX_MAX) ? '0 : index_reg + 1'b1;
    end
  end

  // Shadow only reloads as the scan re-enters digit 0, so a frame never tears.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
      assign shadow_next[gi] = wrap ? ssd_scan_mux_port_digits[gi*4 +: 4] : shadow_reg[gi];
    end
  endgenerate

`ifdef SSD_SCAN_MUX_LZB_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i] is set when digits i..NUM_DIGITS-1 of the next shadow are all zero.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign zero_from[gi] = (shadow_next[gi] == 4'h0);
      end else begin : g_chain
        assign zero_from[gi] = (shadow_next[gi] == 4'h0) && zero_from[gi+1];
      end
    end
  endgenerate

  assign lzb_blank = (index_next != '0) && zero_from[index_next];
`else
  assign lzb_blank = 1'b0;
`endif

  // Outputs are computed from the next state so they align with the slot cycle they describe.
  always_comb begin
    digit_next = shadow_next[index_next];
    lit        = ssd_scan_mux_port_en && (prescaler_next >= DEAD_VAL) && !lzb_blank;
    an_next    = '1;
    if (lit) begin
      an_next[index_next] = 1'b0;
    end
    blank_next = !lit;
    frame_next = wrap;
  end

  always_ff @(posedge ssd_scan_mux_port_clk or posedge ssd_scan_mux_port_rst) begin
    if (ssd_scan_mux_port_rst) begin
      prescaler_reg <= '0;
      index_reg     <= IDX_MAX;
      digit_reg     <= 4'h0;
      an_reg        <= '1;
      blank_reg     <= 1'b1;
      frame_reg     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= 4'h0;
      end
    end else begin
      prescaler_reg <= prescaler_next;
      index_reg     <= index_next;
      digit_reg     <= digit_next;
      an_reg        <= an_next;
      blank_reg     <= blank_next;
      frame_reg     <= frame_next;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i] <= shadow_next[i];
      end
    end
  end

  assign ssd_scan_mux_port_digit = digit_reg;
  assign ssd_scan_mux_port_an    = an_reg;
  assign ssd_scan_mux_port_blank = blank_reg;
  assign ssd_scan_mux_port_frame = frame_reg;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Randomised bench for ssd_scan_mux against a slot/frame level reference model.
// Define SSD_SCAN_MUX_LZB_EN for both files to exercise leading-zero blanking.
module tb_ssd_scan_mux;

  localparam int ND = 2;
  localparam int RD = 8;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [3:0]    digit;
  logic [ND-1:0] an;
  logic          blank;
  logic          frame;

  ssd_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .ssd_scan_mux_port_clk   (clk),
    .ssd_scan_mux_port_rst   (rst),
    .ssd_scan_mux_port_en    (en),
    .ssd_scan_mux_port_digits(digits),
    .ssd_scan_mux_port_digit (digit),
    .ssd_scan_mux_port_an    (an),
    .ssd_scan_mux_port_blank (blank),
    .ssd_scan_mux_port_frame (frame)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Reference state: slot position, digit index, and the frame's latched digits.
  int              m_p;
  int              m_idx;
  logic [4*ND-1:0] m_shadow;
  logic [3:0]      m_digit;
  logic [ND-1:0]   m_an;
  logic            m_blank;
  logic            m_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_idx = ND - 1; m_shadow = '0;
    m_digit = 4'h0; m_an = '1; m_blank = 1'b1; m_frame = 1'b0;
  endtask

  task automatic model_edge();
    bit lit;
    m_frame = 1'b0;
    if (en) begin
      if (m_p == RD - 1) begin
        m_p = 0;
        if (m_idx == ND - 1) begin
          m_idx = 0; m_shadow = digits; m_frame = 1'b1;
        end else begin
          m_idx = m_idx + 1;
        end
      end else begin
        m_p = m_p + 1;
      end
    end
    m_digit = 4'((m_shadow >> (4 * m_idx)) & 'hF);
    lit = en && (m_p >= DC);
`ifdef SSD_SCAN_MUX_LZB_EN
    if (m_idx >= 1 && (m_shadow >> (4 * m_idx)) == 0) lit = 1'b0;
`endif
    m_an = '1;
    if (lit) m_an[m_idx] = 1'b0;
    m_blank = !lit;
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    if (!rst) model_edge();
    #1;
    chk("digit", 32'(digit), 32'(m_digit));
    chk("an",    32'(an),    32'(m_an));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("frame", 32'(frame), 32'(m_frame));
  endtask

  task automatic wait_slot(input int idx, input int p);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (m_idx == idx && m_p == p) found = 1'b1;
    end
    if (!found) chk("wait_slot_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int n;
    model_reset();
    for (int i = 0; i < 3; i++) step();

    // First frame latency from reset release.
    rst = 1'b0; en = 1'b1; digits = 8'h47;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (frame) lat = i;
    end
    chk("first_frame_latency", lat, 8);
    for (int i = 0; i < 32; i++) step();

    // Asynchronous reset mid-slot while digit 0 is lit.
    wait_slot(0, 4);
    chk("pre_reset_an", 32'(an), 32'(2'b10));
    #3 rst = 1'b1;
    #1;
    chk("async_an",    32'(an),    32'(2'b11));
    chk("async_digit", 32'(digit), 0);
    chk("async_blank", 32'(blank), 1);
    chk("async_frame", 32'(frame), 0);
    model_reset();
    #1 rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      step();
      if (frame) lat = i;
    end
    chk("reframe_latency", lat, 8);

    // Coherence: digit change during slot 0 waits for the next frame.
    wait_slot(0, 3);
    digits = 8'h93;
    wait_slot(1, DC);
    chk("coh_slot1_old", 32'(digit), 4);
    wait_slot(0, DC);
    chk("coh_slot0_new", 32'(digit), 3);
    wait_slot(1, DC);
    chk("coh_slot1_new", 32'(digit), 9);

    // Enable drop mid-slot 1.
    wait_slot(1, 4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_off_an",    32'(an),    32'(2'b11));
      chk("en_off_blank", 32'(blank), 1);
    end
    en = 1'b1;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      step();
      if (frame) n = i;
    end
    chk("resume_remaining", n, 4);

    // Hex pass-through.
    digits = 8'hFA;
    wait_slot(1, DC);
    wait_slot(0, DC);
    chk("hex_slot0", 32'(digit), 32'hA);
    wait_slot(1, DC);
    chk("hex_slot1", 32'(digit), 32'hF);

    // Leading zero handling.
    digits = 8'h05;
    wait_slot(0, DC);
    chk("lz05_slot0_digit", 32'(digit), 5);
    chk("lz05_slot0_an",    32'(an),    32'(2'b10));
    wait_slot(1, 4);
`ifdef SSD_SCAN_MUX_LZB_EN
    chk("lz05_slot1_an", 32'(an), 32'(2'b11));
`else
    chk("lz05_slot1_an", 32'(an), 32'(2'b01));
`endif
    digits = 8'h00;
    wait_slot(0, 4);
    chk("lz00_slot0_an",    32'(an),    32'(2'b10));
    chk("lz00_slot0_digit", 32'(digit), 0);

    // Random enable and digit traffic.
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) digits = 8'($urandom);
      if ($urandom_range(0, 29) == 0) digits = {4'h0, 4'($urandom)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
